ftq_redirect_mem_arb: RTL and testbench
=======================================

Name: ftq_redirect_mem_arb

Overview:
- Read-port arbiter and sequencer for the 64-entry FTQ redirect-info memory. The memory has synchronous read (data 1 cycle after ren/raddr) and one write port.
- Shares N_RP memory read ports among N_REQ requesters: backend redirect (req 0), IFU redirect, update, and misc pre-decode readers.
- Returns each granted read one cycle later, routed to its requester.
- Tracks an entry-written bitmap. Optionally forwards same-cycle writes into read responses.

Parameters:
- N_REQ, 4, number of read requesters; req 0 has fixed top priority.
- N_RP, 2, number of memory read ports used (N_RP ≤ N_REQ).
- AW, 6, entry address width (64 entries).
- DATA_W, 84, packed entry width: histPtr 9, ssp 4, sctr 3, TOSW 6, TOSR 6, NOS 6, topAddr 50.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  read request per requester
- req_addr  in  N_REQ*AW  request address, requester i at [i*AW +: AW]
- req_ready  out  N_REQ  grant this cycle; a request is accepted when valid&ready
- rsp_valid  out  N_REQ  response for the request accepted the previous cycle
- rsp_data  out  N_REQ*DATA_W  response entry
- rsp_hit  out  N_REQ  entry written since last clear
- wr_valid  in  1  write request (always accepted)
- wr_addr  in  AW  write address
- wr_data  in  DATA_W  write data
- clear  in  1  clear the written bitmap
- mem_ren  out  N_RP  memory read enables
- mem_raddr  out  N_RP*AW  memory read addresses
- mem_rdata  in  N_RP*DATA_W  memory read data, valid the cycle after mem_ren
- mem_wen  out  1  memory write enable (= wr_valid)
- mem_waddr  out  AW  = wr_addr
- mem_wdata  out  DATA_W  = wr_data

Behaviour:
- Reset values: rsp_valid 0; rsp_data 0; rsp_hit 0; RR pointer 1; written bitmap all 0; port-map registers invalid.
- Grant (combinational, cycle T):
  - If req_valid[0], requester 0 gets port 0 (req_ready[0]=1).
  - Remaining free ports go to requesters 1..N_REQ-1 in round-robin order, starting at the RR pointer, one port per requester.
  - req_ready[i]=1 iff granted. Ungranted requesters must hold req_valid and req_addr.
- Memory drive: mem_ren[p]=1 and mem_raddr[p]=granted address for each granted port p. Unused ports: mem_ren 0, mem_raddr 0.
- RR pointer: after a cycle with any grant among 1..N_REQ-1, moves to the requester after the last one granted, wrapping N_REQ-1 → 1. Otherwise unchanged.
- Port map: registered at T: per port, owner id, address and valid.
- Response (T+1): rsp_valid[owner]=1 and rsp_data[owner]=mem_rdata[p]. Latency is exactly 1 cycle; no backpressure on responses.
- Requester-0 stream: a continuous stream is accepted every cycle, giving 1 response per cycle.
- Bitmap:
  - On wr_valid, bit[wr_addr] is set at the clock edge.
  - On clear, all bits are zeroed at the edge. If clear and wr_valid occur together, the write wins for its own bit.
  - rsp_hit[owner] = bitmap[addr] as of T+1, before that edge's update.
- Write path: combinational pass-through. Write/read collisions on the memory are resolved by the optional bypass.
- Mid-operation reset: in-flight responses are dropped. No rsp_valid appears in the first cycle after reset release.

Optional Feature:
- FTQ_RMEM_BYPASS_EN defined:
  - In the response cycle T+1, if wr_valid and wr_addr equal a responding port's address, rsp_data = wr_data and rsp_hit = 1.
  - Also, a write in cycle T to the same address as a read issued in T is captured, and its wr_data is returned at T+1.
  - If both apply, the T+1 write has priority.
- Undefined: rsp_data is always mem_rdata; no forwarding logic and no captured-write registers.

Decomposition:
- Shared package ftq_rmem_pkg holds:
  - AW and DATA_W constants.
  - The packed redirect-entry typedef with field offsets (histPtr, ssp, sctr, TOSW, TOSR, NOS, topAddr).
  - The port-map record typedef (valid, owner, addr).
- One sub-module: ftq_rmem_rr_grant, a round-robin N-way picker with a pointer input that returns up to K one-hot grants.

Test Plan:
- Reset, then write addr 5 = 0xA5…; req1 reads addr 5 → req_ready[1]=1; at T+1 rsp_valid[1]=1, rsp_data=0xA5…, rsp_hit=1.
- req0..3 all valid for 4 cycles, N_RP=2 → req0 granted every cycle; port 1 grants req1, req2, req3, req1 in order; each response 1 cycle after its grant.
- clear and wr_valid addr 7 in the same cycle, then read addr 7 and addr 8 → rsp_hit 1 and 0 respectively.
- Bypass on: read addr 3 at T, write addr 3 = 0x55 at T+1 → rsp_data=0x55 at T+1. Bypass off → old memory value.
- Assert reset in the cycle after a grant → rsp_valid stays 0; RR pointer =1; bitmap zero after release.
- Requester 2 valid while req0, req1, req3 all valid for 6 cycles → req2 granted within 2 cycles (no starvation).

Source files
------------

// File: rtl/ftq_rmem_pkg.sv
// Shared types for the FTQ redirect-info memory read arbiter.
// Optional write forwarding is enabled by FTQ_RMEM_BYPASS_EN.
package ftq_rmem_pkg;

  localparam int AW     = 6;
  localparam int DATA_W = 84;
  localparam int N_ENT  = 1 << AW;
  localparam int OWN_W  = 4;

  localparam int TOP_LSB  = 0;
  localparam int NOS_LSB  = 50;
  localparam int TOSR_LSB = 56;
  localparam int TOSW_LSB = 62;
  localparam int SCTR_LSB = 68;
  localparam int SSP_LSB  = 71;
  localparam int HIST_LSB = 75;

  typedef struct packed {
    logic [8:0]  hist_ptr;
    logic [3:0]  ssp;
    logic [2:0]  sctr;
    logic [5:0]  tosw;
    logic [5:0]  tosr;
    logic [5:0]  nos;
    logic [49:0] top_addr;
  } rentry_t;

  typedef struct packed {
    logic             valid;
    logic [OWN_W-1:0] owner;
    logic [AW-1:0]    addr;
  } pmap_t;

endpackage

// File: rtl/ftq_redirect_mem_arb_if.sv
// Requester, write and memory-side bundle of the redirect-memory
// arbiter; slave is the arbiter, master is its environment.
interface ftq_redirect_mem_arb_if
  import ftq_rmem_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_RP  = 2
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*AW-1:0]     req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ*DATA_W-1:0] rsp_data;
  logic [N_REQ-1:0]        rsp_hit;
  logic                    wr_valid;
  logic [AW-1:0]           wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    clear;
  logic [N_RP-1:0]         mem_ren;
  logic [N_RP*AW-1:0]      mem_raddr;
  logic [N_RP*DATA_W-1:0]  mem_rdata;
  logic                    mem_wen;
  logic [AW-1:0]           mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;

  modport slave (
    input  req_valid, req_addr,
    input  wr_valid, wr_addr, wr_data,
    input  clear, mem_rdata,
    output req_ready, rsp_valid,
    output rsp_data, rsp_hit,
    output mem_ren, mem_raddr,
    output mem_wen, mem_waddr, mem_wdata
  );

  modport master (
    output req_valid, req_addr,
    output wr_valid, wr_addr, wr_data,
    output clear, mem_rdata,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_hit,
    input  mem_ren, mem_raddr,
    input  mem_wen, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/ftq_rmem_rr_grant.sv
// Round-robin picker: up to K one-hot grants out of N requests,
// searched in wrap-around order starting at ptr_i.
module ftq_rmem_rr_grant #(
  parameter int N  = 3,
  parameter int K  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [K-1:0][N-1:0] gnt_o
);

  logic [N-1:0]   mask;
  logic [N-1:0]   rot;
  logic [N-1:0]   low;
  logic [2*N-1:0] dbl;

  always_comb begin
    mask  = req_i;
    gnt_o = '0;
    rot   = '0;
    low   = '0;
    dbl   = '0;
    for (int k = 0; k < K; k++) begin
      // rotate so ptr is bit 0, isolate lowest, rotate back
      dbl      = {mask, mask} >> ptr_i;
      rot      = dbl[N-1:0];
      low      = rot & (~rot + 1'b1);
      dbl      = {low, low} << ptr_i;
      gnt_o[k] = dbl[2*N-1:N];
      mask     = mask & ~gnt_o[k];
    end
  end

endmodule

// File: rtl/ftq_redirect_mem_arb.sv
// FTQ redirect-info memory read arbiter and written-entry tracker.
// Define FTQ_RMEM_BYPASS_EN to forward writes into read responses.
module ftq_redirect_mem_arb
  import ftq_rmem_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_RP  = 2
) (
  input logic clock,
  input logic reset,
  ftq_redirect_mem_arb_if.slave bus
);

  localparam int NR = N_REQ - 1;
  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  pmap_t [N_RP-1:0]             pm_d, pm_q;
  logic [N_ENT-1:0]             bm_d, bm_q;
  logic [OWN_W-1:0]             rr_d, rr_q;
  logic [PW-1:0]                ptr;
  logic [N_RP-1:0][NR-1:0]      pick;
  logic [N_RP:0][NR-1:0]        pick_ext;
  logic [NR-1:0]                sel;
  logic [N_RP-1:0][DATA_W-1:0]  rd;
  logic [N_RP-1:0]              hit;

  assign ptr = PW'(rr_q - OWN_W'(1));

  ftq_rmem_rr_grant #(
    .N (NR),
    .K (N_RP),
    .PW(PW)
  ) u_grant (
    .req_i(bus.req_valid[N_REQ-1:1]),
    .ptr_i(ptr),
    .gnt_o(pick)
  );

  assign bus.mem_wen   = bus.wr_valid;
  assign bus.mem_waddr = bus.wr_addr;
  assign bus.mem_wdata = bus.wr_data;

  always_comb begin
    pick_ext      = {pick, {NR{1'b0}}};
    pm_d          = '0;
    sel           = '0;
    rr_d          = rr_q;
    bus.req_ready = '0;
    bus.mem_ren   = '0;
    bus.mem_raddr = '0;
    for (int p = 0; p < N_RP; p++) begin
      if (p == 0 && bus.req_valid[0]) begin
        pm_d[p].valid    = 1'b1;
        pm_d[p].owner    = '0;
        pm_d[p].addr     = bus.req_addr[0 +: AW];
        bus.req_ready[0] = 1'b1;
      end else begin
        // port 0 is taken by req 0, so picks shift up one port
        sel = bus.req_valid[0] ? pick_ext[p]
                               : pick_ext[p+1];
        for (int i = 0; i < NR; i++) begin
          if (sel[i]) begin
            pm_d[p].valid      = 1'b1;
            pm_d[p].owner      = OWN_W'(i + 1);
            pm_d[p].addr       = bus.req_addr[(i+1)*AW +: AW];
            bus.req_ready[i+1] = 1'b1;
            rr_d = (i + 1 == NR) ? OWN_W'(1)
                                 : OWN_W'(i + 2);
          end
        end
      end
      bus.mem_ren[p]            = pm_d[p].valid;
      bus.mem_raddr[p*AW +: AW] = pm_d[p].addr;
    end
  end

  always_comb begin
    bm_d = bus.clear ? '0 : bm_q;
    if (bus.wr_valid) bm_d[bus.wr_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pm_q <= '0;
      bm_q <= '0;
      rr_q <= OWN_W'(1);
    end else begin
      pm_q <= pm_d;
      bm_q <= bm_d;
      rr_q <= rr_d;
    end
  end

`ifdef FTQ_RMEM_BYPASS_EN
  logic [N_RP-1:0]             cap_vld_d, cap_vld_q;
  logic [N_RP-1:0][DATA_W-1:0] cap_dat_d, cap_dat_q;

  always_comb begin
    cap_vld_d = '0;
    cap_dat_d = '0;
    for (int p = 0; p < N_RP; p++) begin
      cap_vld_d[p] = pm_d[p].valid && bus.wr_valid
                     && bus.wr_addr == pm_d[p].addr;
      cap_dat_d[p] = bus.wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_vld_q <= '0;
      cap_dat_q <= '0;
    end else begin
      cap_vld_q <= cap_vld_d;
      cap_dat_q <= cap_dat_d;
    end
  end
`endif

  always_comb begin
    rd            = '0;
    hit           = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_hit   = '0;
    for (int p = 0; p < N_RP; p++) begin
      rd[p]  = bus.mem_rdata[p*DATA_W +: DATA_W];
      hit[p] = bm_q[pm_q[p].addr];
`ifdef FTQ_RMEM_BYPASS_EN
      if (cap_vld_q[p]) rd[p] = cap_dat_q[p];
      if (bus.wr_valid && bus.wr_addr == pm_q[p].addr) begin
        rd[p]  = bus.wr_data;
        hit[p] = 1'b1;
      end
`endif
      for (int i = 0; i < N_REQ; i++) begin
        if (pm_q[p].valid && pm_q[p].owner == OWN_W'(i)) begin
          bus.rsp_valid[i]               = 1'b1;
          bus.rsp_data[i*DATA_W +: DATA_W] = rd[p];
          bus.rsp_hit[i]                 = hit[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_ftq_redirect_mem_arb.sv
// Directed bench: grant/response vector table plus hand sequences
// for write hit, clear, write forwarding, reset and fairness.
module tb_ftq_redirect_mem_arb;
  import ftq_rmem_pkg::*;

  localparam int NQ = 4;
  localparam int NP = 2;
`ifdef FTQ_RMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [DATA_W-1:0] DA5 = {4'hA, {10{8'hA5}}};
  localparam logic [DATA_W-1:0] D7  = 84'h7_0707;
  localparam logic [DATA_W-1:0] D8  = 84'h8_0808;
  localparam logic [DATA_W-1:0] D55 = 84'h55;
  localparam logic [DATA_W-1:0] D77 = 84'h77;

  logic clock;
  logic reset;
  logic mem_load;
  int   errs;
  int   checks;

  always begin
    clock = 1'b0;
    #5;
    clock = 1'b1;
    #5;
  end

  ftq_redirect_mem_arb_if #(.N_REQ(NQ), .N_RP(NP)) bus ();

  ftq_redirect_mem_arb #(.N_REQ(NQ), .N_RP(NP)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [DATA_W-1:0] pat(input int a);
    return {8'hC3, 20'(a * 7), 50'(a) << 4, 6'(a)};
  endfunction

  logic [DATA_W-1:0] mem [N_ENT];

  // synchronous-read memory, read-before-write on collisions
  always @(posedge clock) begin
    for (int p = 0; p < NP; p++)
      if (bus.mem_ren[p])
        bus.mem_rdata[p*DATA_W +: DATA_W] <=
          mem[bus.mem_raddr[p*AW +: AW]];
    if (mem_load) begin
      for (int a = 0; a < N_ENT; a++) mem[a] <= pat(a);
    end else if (bus.mem_wen) begin
      mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string nm,
                     input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdat(input int i);
    return bus.rsp_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clear     = 1'b0;
  endtask

  task automatic set_req(input logic [NQ-1:0] v,
                         input logic [AW-1:0] a0, a1, a2, a3);
    bus.req_valid = v;
    bus.req_addr  = {a3, a2, a1, a0};
  endtask

  task automatic set_wr(input logic [AW-1:0] a,
                        input logic [DATA_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
  endtask

  // after the active edge: drop inputs, then let comb settle
  task automatic past_edge();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  typedef struct {
    logic [NQ-1:0] v;
    logic [NQ-1:0] rdy;
    logic [NP-1:0] ren;
    logic [AW-1:0] a0;
  } vec_t;

  vec_t          tbl [10];
  logic [NQ-1:0] rdy;
  int            cnt [NQ];
  int            first2;

  initial begin
    tbl[0] = '{4'b1111, 4'b0011, 2'b11, 6'd10};
    tbl[1] = '{4'b1111, 4'b0101, 2'b11, 6'd10};
    tbl[2] = '{4'b1111, 4'b1001, 2'b11, 6'd10};
    tbl[3] = '{4'b1111, 4'b0011, 2'b11, 6'd10};
    tbl[4] = '{4'b1110, 4'b1100, 2'b11, 6'd12};
    tbl[5] = '{4'b0110, 4'b0110, 2'b11, 6'd11};
    tbl[6] = '{4'b0100, 4'b0100, 2'b01, 6'd12};
    tbl[7] = '{4'b1010, 4'b1010, 2'b11, 6'd13};
    tbl[8] = '{4'b0000, 4'b0000, 2'b00, 6'd0};
    tbl[9] = '{4'b0011, 4'b0011, 2'b11, 6'd10};

    errs     = 0;
    checks   = 0;
    first2   = -1;
    for (int i = 0; i < NQ; i++) cnt[i] = 0;
    idle();
    reset    = 1'b0;
    mem_load = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_data", |bus.rsp_data, 0);
    chk("rst rsp_hit", bus.rsp_hit, 0);
    chk("rst mem_ren", bus.mem_ren, 0);
    @(negedge clock);
    reset    = 1'b1;
    mem_load = 1'b0;
    past_edge();
    chk("post-rst rsp_valid", bus.rsp_valid, 0);

    for (int r = 0; r < 10; r++) begin
      @(negedge clock);
      idle();
      set_req(tbl[r].v, 6'd10, 6'd11, 6'd12, 6'd13);
      #1;
      chk($sformatf("row%0d ready", r), bus.req_ready, tbl[r].rdy);
      chk($sformatf("row%0d ren", r), bus.mem_ren, tbl[r].ren);
      chk($sformatf("row%0d raddr0", r),
          bus.mem_raddr[AW-1:0], tbl[r].a0);
      past_edge();
      chk($sformatf("row%0d rsp_valid", r),
          bus.rsp_valid, tbl[r].rdy);
      for (int i = 0; i < NQ; i++) begin
        if (tbl[r].rdy[i]) begin
          chk($sformatf("row%0d data%0d", r, i), rdat(i), pat(10 + i));
          chk($sformatf("row%0d hit%0d", r, i), bus.rsp_hit[i], 0);
        end
      end
    end

    // write 5, then read it back through requester 1
    @(negedge clock);
    idle();
    set_wr(6'd5, DA5);
    #1;
    chk("wr mem_wen", bus.mem_wen, 1);
    chk("wr mem_waddr", bus.mem_waddr, 5);
    chk("wr mem_wdata", bus.mem_wdata, DA5);
    @(negedge clock);
    idle();
    set_req(4'b0010, 6'd0, 6'd5, 6'd0, 6'd0);
    #1;
    chk("rd5 ready", bus.req_ready, 4'b0010);
    past_edge();
    chk("rd5 rsp_valid", bus.rsp_valid, 4'b0010);
    chk("rd5 data", rdat(1), DA5);
    chk("rd5 hit", bus.rsp_hit[1], 1);

    // write 8, then clear together with a write of 7
    @(negedge clock);
    idle();
    set_wr(6'd8, D8);
    @(negedge clock);
    idle();
    set_wr(6'd7, D7);
    bus.clear = 1'b1;
    @(negedge clock);
    idle();
    set_req(4'b0110, 6'd0, 6'd7, 6'd8, 6'd0);
    #1;
    chk("clr ready", bus.req_ready, 4'b0110);
    past_edge();
    chk("clr rsp_valid", bus.rsp_valid, 4'b0110);
    chk("clr hit7", bus.rsp_hit[1], 1);
    chk("clr hit8", bus.rsp_hit[2], 0);
    chk("clr data7", rdat(1), D7);
    chk("clr data8", rdat(2), D8);

    // write in the response cycle
    @(negedge clock);
    idle();
    set_req(4'b0010, 6'd0, 6'd3, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    idle();
    set_wr(6'd3, D55);
    #1;
    chk("byp1 rsp_valid", bus.rsp_valid, 4'b0010);
    chk("byp1 data", rdat(1), BYP ? D55 : pat(3));
    chk("byp1 hit", bus.rsp_hit[1], BYP);

    // write in the same cycle as the read
    @(negedge clock);
    idle();
    set_req(4'b0010, 6'd0, 6'd4, 6'd0, 6'd0);
    set_wr(6'd4, D77);
    past_edge();
    chk("byp0 rsp_valid", bus.rsp_valid, 4'b0010);
    chk("byp0 data", rdat(1), BYP ? D77 : pat(4));
    chk("byp0 hit", bus.rsp_hit[1], 1);

    // grant req 2 (pointer moves to 3), then reset while in flight
    @(negedge clock);
    idle();
    set_req(4'b0100, 6'd0, 6'd0, 6'd4, 6'd0);
    #1;
    chk("mrst ready", bus.req_ready, 4'b0100);
    @(posedge clock);
    #1;
    idle();
    reset = 1'b0;
    #1;
    chk("mrst drop", bus.rsp_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    past_edge();
    chk("mrst first", bus.rsp_valid, 0);
    @(negedge clock);
    idle();
    set_req(4'b1110, 6'd0, 6'd7, 6'd4, 6'd9);
    #1;
    chk("mrst rr ready", bus.req_ready, 4'b0110);
    past_edge();
    chk("mrst rsp_valid", bus.rsp_valid, 4'b0110);
    chk("mrst hit7", bus.rsp_hit[1], 0);
    chk("mrst hit4", bus.rsp_hit[2], 0);

    // all four requesting: req 0 every cycle, others rotate
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      idle();
      set_req(4'b1111, 6'd20, 6'd21, 6'd22, 6'd23);
      #1;
      rdy = bus.req_ready;
      chk($sformatf("fair%0d r0", c), rdy[0], 1);
      for (int i = 0; i < NQ; i++) if (rdy[i]) cnt[i]++;
      if (rdy[2] && first2 < 0) first2 = c;
      past_edge();
      chk($sformatf("fair%0d rsp", c), bus.rsp_valid, rdy);
    end
    chk("fair req2 wait", (first2 >= 0 && first2 < 3), 1);
    for (int i = 1; i < NQ; i++)
      chk($sformatf("fair cnt%0d", i), cnt[i], 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
